pc_next_reg: RTL and testbench
==============================

# pc_next_reg

Program-counter register and next-PC selection stage of the single-cycle CPU. Consumes the PC+4 value produced by the PC incrementer and picks the next fetch address from PC+4, a branch target or a jump target. Holds the PC while the instruction or data memory signals busywait. Latches a redirect that is decided during a stalled cycle and applies it once the stall clears. Its PC output drives instruction fetch and the PC incrementer.

## Interface
- No parameters; widths are fixed by the package constants.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- BUSYWAIT  in  1  memory stall; 1 = hold PC.
- INSTR_VALID  in  1  decode outputs (JUMP/BRANCH/BNE/OFFSET) are valid this cycle.
- PCADDED  in  32  PC+4 from the incrementer; valid before each rising edge.
- JUMP  in  1  unconditional jump.
- BRANCH  in  1  branch-if-equal.
- BNE  in  1  branch-if-not-equal.
- ZERO  in  1  ALU zero flag.
- OFFSET  in  8  signed word offset, two's complement.
- PC  out  32  current fetch address.
- REDIRECT_CNT  out  16  taken-redirect count; present only with PC_REDIRECT_CNT_EN.

## Operation
- Target address: PCADDED + (sign_extend(OFFSET) << 2), computed modulo 2^32 (wraps silently).
- Taken condition: INSTR_VALID & (JUMP | (BRANCH & ZERO) | (BNE & ~ZERO)).
- If JUMP and a branch are both asserted, JUMP wins; the target formula is the same for both.
- FSM states: RUN, PEND.
- RUN with BUSYWAIT=0:
  - taken: PC <= target.
  - not taken: PC <= PCADDED.
- RUN with BUSYWAIT=1:
  - PC holds.
  - If taken, the target goes into the pending register and the state moves to PEND.
- PEND with BUSYWAIT=1: PC holds; INSTR_VALID and the redirect inputs are ignored.
- PEND with BUSYWAIT=0: PC <= pending target; state returns to RUN. PCADDED is not used that cycle.
- Only one redirect can be pending. Later redirects are ignored while in PEND, because the upstream decode is frozen during a stall.
- A not-taken instruction in a stalled cycle changes no state.

## Timing
- Reset (asynchronous, immediate):
  - PC = 32'h0000_0000.
  - State = RUN.
  - Pending register = 0.
  - REDIRECT_CNT = 0.
- Reset asserted in PEND discards the pending redirect.
- Latency:
  - Sequential or redirect: PC updates at the first rising edge with BUSYWAIT=0.
  - Stalled redirect: PC takes the target at the first edge after BUSYWAIT falls.
- PC is a register output; there is no combinational path from any input to PC.
- Inputs are sampled only at the rising edge. Glitches between edges have no effect.

## Configuration
- Macro: PC_REDIRECT_CNT_EN.
- Defined:
  - REDIRECT_CNT port exists.
  - The 16-bit counter increments once per redirect actually applied to PC, either directly from RUN or on the PEND to RUN transition.
  - The counter saturates at 16'hFFFF and is cleared only by RESET.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package / include file:
  - PC_W = 32, OFFSET_W = 8, CNT_W = 16.
  - PC_RESET_VAL = 32'h0.
  - State encoding: RUN = 1'b0, PEND = 1'b1.
- One sub-module, pc_target_calc: a combinational sign-extend, shift and add that produces the target.
- FSM, pending register, PC register and counter live in pc_next_reg.

## Test plan
- Reset, then 3 edges with BUSYWAIT=0 and no redirect (PCADDED driven as PC+4) → PC = 0, 4, 8, 12. Assert RESET mid-cycle → PC = 0 immediately, without waiting for an edge.
- PC = 0x10, JUMP=1, OFFSET=8'h02, INSTR_VALID=1 → next PC = 0x1C. With OFFSET=8'hFE → next PC = 0x0C.
- PC = 0x20, BRANCH=1:
  - ZERO=1 → next PC = target.
  - ZERO=0 → next PC = 0x24.
  - Same pair for BNE with the outcomes inverted.
  - JUMP=1 and BRANCH=1 with ZERO=0 → PC takes the target.
- PC = 0x40, BUSYWAIT=1 for 3 cycles, JUMP with OFFSET=8'h04 valid only in the first stalled cycle → PC holds 0x40 and state = PEND. After BUSYWAIT drops → PC = 0x54 and REDIRECT_CNT += 1.
- In PEND, assert RESET → PC = 0 and state = RUN. After release with BUSYWAIT=0 → PC = 4, so the pending target is not applied.
- PC = 0xFFFF_FFFC, PCADDED = 0, JUMP with OFFSET=8'h01 → PC = 0x4 (wrap-around). With the macro defined, force 65535 redirects then one more → REDIRECT_CNT stays 16'hFFFF.

Source files
------------

// File: rtl/pc_next_reg_pkg.sv
// Shared widths, reset value and FSM encoding for the PC register stage.
// Optional feature macro used by this block: PC_REDIRECT_CNT_EN.
package pc_next_reg_pkg;

    localparam int PC_W     = 32;
    localparam int OFFSET_W = 8;
    localparam int CNT_W    = 16;

    localparam logic [PC_W-1:0] PC_RESET_VAL = 32'h0;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Branch/jump target: PC+4 plus the sign-extended word offset scaled to bytes.
// Purely combinational; the sum wraps modulo 2^32.
module pc_target_calc
    import pc_next_reg_pkg::*;
(
    input  logic [PC_W-1:0]     PCADDED,
    input  logic [OFFSET_W-1:0] OFFSET,
    output logic [PC_W-1:0]     TARGET
);

    logic [PC_W-1:0] byte_offset;

    assign byte_offset = {{(PC_W-OFFSET_W-2){OFFSET[OFFSET_W-1]}}, OFFSET, 2'b00};
    assign TARGET      = PCADDED + byte_offset;

endmodule

// File: rtl/pc_next_reg.sv
// PC register with next-PC selection and one-deep pending redirect across stalls.
// Define PC_REDIRECT_CNT_EN to add the saturating REDIRECT_CNT output.
module pc_next_reg
    import pc_next_reg_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BUSYWAIT,
    input  logic                INSTR_VALID,
    input  logic [PC_W-1:0]     PCADDED,
    input  logic                JUMP,
    input  logic                BRANCH,
    input  logic                BNE,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] OFFSET,
    output logic [PC_W-1:0]     PC,
    output pc_state_e           DBG_STATE
`ifdef PC_REDIRECT_CNT_EN
   ,output logic [CNT_W-1:0]    REDIRECT_CNT
`endif
);

    // Handshake: decode outputs count only when INSTR_VALID is high at an edge;
    // BUSYWAIT high means the edge is not accepted, so PC does not advance.
    pc_state_e       state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_q;
    logic [PC_W-1:0] target;
    logic            taken;

    pc_target_calc u_target (
        .PCADDED (PCADDED),
        .OFFSET  (OFFSET),
        .TARGET  (target)
    );

    // JUMP and branch share one target, so priority between them is moot.
    assign taken = INSTR_VALID & (JUMP | (BRANCH & ZERO) | (BNE & ~ZERO));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q   <= PC_RESET_VAL;
            pend_q <= '0;
            state  <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (!BUSYWAIT) begin
                        pc_q <= taken ? target : PCADDED;
                    end else if (taken) begin
                        pend_q <= target;
                        state  <= PEND;
                    end
                end
                PEND: begin
                    // Decode is frozen while stalled, so new redirects are ignored here.
                    if (!BUSYWAIT) begin
                        pc_q  <= pend_q;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign PC        = pc_q;
    assign DBG_STATE = state;

`ifdef PC_REDIRECT_CNT_EN
    logic             redirect_applied;
    logic [CNT_W-1:0] cnt_q;

    assign redirect_applied = !BUSYWAIT && ((state == PEND) || taken);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (redirect_applied && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign REDIRECT_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_reg.sv
// Self-checking bench for pc_next_reg: directed plan steps then random cycles
// checked against a queue-based reference model.
module tb_pc_next_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        busywait;
    logic        instr_valid;
    logic [31:0] pcadded;
    logic        jump;
    logic        branch;
    logic        bne;
    logic        zero;
    logic [7:0]  offset;
    logic [31:0] pc;
    logic        dbg_state;
`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    pc_next_reg dut (
        .CLK          (clk),
        .RESET        (rst),
        .BUSYWAIT     (busywait),
        .INSTR_VALID  (instr_valid),
        .PCADDED      (pcadded),
        .JUMP         (jump),
        .BRANCH       (branch),
        .BNE          (bne),
        .ZERO         (zero),
        .OFFSET       (offset),
        .PC           (pc),
        .DBG_STATE    (dbg_state)
`ifdef PC_REDIRECT_CNT_EN
       ,.REDIRECT_CNT (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: architectural PC, queue of at most one deferred target, count.
    logic [31:0] m_pc;
    logic [31:0] pend_q[$];
    int          m_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_state"}, {31'b0, dbg_state}, {31'b0, pend_q.size() != 0});
`ifdef PC_REDIRECT_CNT_EN
        check({tag, "_cnt"}, {16'b0, redirect_cnt}, 32'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        pend_q.delete();
        m_cnt = 0;
    endtask

    task automatic bump();
        if (m_cnt < 65535) m_cnt++;
    endtask

    // Drive at a falling edge, let one rising edge happen, check at the next falling edge.
    task automatic step(input logic busy, input logic valid, input logic [31:0] pa,
                        input logic j, input logic b, input logic n, input logic z,
                        input logic [7:0] off, input string tag);
        logic        tk;
        logic [31:0] tgt;
        int          o;
        busywait    = busy;
        instr_valid = valid;
        pcadded     = pa;
        jump        = j;
        branch      = b;
        bne         = n;
        zero        = z;
        offset      = off;
        @(posedge clk);
        tk  = valid && (j || (b && z) || (n && !z));
        o   = $signed(off);
        tgt = pa + 32'(o * 4);
        if (pend_q.size() != 0) begin
            if (!busy) begin
                m_pc = pend_q.pop_front();
                bump();
            end
        end else if (tk) begin
            if (busy) pend_q.push_back(tgt);
            else begin
                m_pc = tgt;
                bump();
            end
        end else if (!busy) begin
            m_pc = pa;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic seq(input string tag);
        step(1'b0, 1'b0, m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tag);
    endtask

    task automatic jmp(input logic [7:0] off, input string tag);
        step(1'b0, 1'b1, m_pc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, off, tag);
    endtask

    task automatic goto_addr(input logic [31:0] addr);
        int d;
        d = int'(addr - (m_pc + 32'd4));
        jmp(8'(d / 4), "goto");
    endtask

    // Reset raised between edges must clear PC before any rising edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_pc_now"}, pc, 32'h0);
        check({tag, "_state_now"}, {31'b0, dbg_state}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt_before;
        rst = 1'b1;
        busywait = 1'b0; instr_valid = 1'b0; pcadded = '0;
        jump = 1'b0; branch = 1'b0; bne = 1'b0; zero = 1'b0; offset = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        seq("seq1"); check("seq1_c", pc, 32'h4);
        seq("seq2"); check("seq2_c", pc, 32'h8);
        seq("seq3"); check("seq3_c", pc, 32'hC);
        async_reset("mid_reset");

        repeat (4) seq("seq");
        jmp(8'h02, "jump_fwd"); check("jump_fwd_c", pc, 32'h1C);
        goto_addr(32'h10);
        jmp(8'hFE, "jump_back"); check("jump_back_c", pc, 32'h0C);

        goto_addr(32'h20);
        step(1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, "beq_t");
        check("beq_t_c", pc, 32'h2C);
        goto_addr(32'h20);
        step(1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, "beq_nt");
        check("beq_nt_c", pc, 32'h24);
        goto_addr(32'h20);
        step(1'b0, 1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, "bne_t");
        check("bne_t_c", pc, 32'h2C);
        goto_addr(32'h20);
        step(1'b0, 1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, "bne_nt");
        check("bne_nt_c", pc, 32'h24);
        goto_addr(32'h20);
        step(1'b0, 1'b1, 32'h24, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, "jump_beq");
        check("jump_beq_c", pc, 32'h2C);
        goto_addr(32'h20);
        step(1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, "invalid_jump");
        check("invalid_jump_c", pc, 32'h24);

        goto_addr(32'h40);
        cnt_before = m_cnt;
        step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, "stall_jump");
        check("stall_hold_c", pc, 32'h40);
        check("stall_pend_c", {31'b0, dbg_state}, 32'h1);
        step(1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "stall2");
        step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, "stall3_ignored");
        check("stall3_hold_c", pc, 32'h40);
        step(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, "stall_release");
        check("stall_release_c", pc, 32'h54);
        check("stall_release_run_c", {31'b0, dbg_state}, 32'h0);
`ifdef PC_REDIRECT_CNT_EN
        check("stall_release_cnt_c", {16'b0, redirect_cnt}, 32'(cnt_before + 1));
`endif
        step(1'b1, 1'b0, 32'h58, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "stall_nt");
        check("stall_nt_c", pc, 32'h54);

        goto_addr(32'h60);
        step(1'b1, 1'b1, 32'h64, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, "pend_for_reset");
        async_reset("pend_reset");
        step(1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "after_pend_reset");
        check("after_pend_reset_c", pc, 32'h4);

        jmp(8'h80, "far_back");
        goto_addr(32'hFFFF_FFFC);
        check("near_top_c", pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, "wrap");
        check("wrap_c", pc, 32'h4);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] pa;
            pa = ($urandom_range(0, 7) == 0) ? 32'($urandom) : m_pc + 32'd4;
            step(($urandom_range(0, 2) == 0), 1'($urandom), pa,
                 ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), "rand");
        end

`ifdef PC_REDIRECT_CNT_EN
        busywait = 1'b0; instr_valid = 1'b1; pcadded = 32'h0;
        jump = 1'b1; branch = 1'b0; bne = 1'b0; zero = 1'b0; offset = 8'h00;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        m_pc  = 32'h0;
        m_cnt = 65535;
        check("sat_cnt_c", {16'b0, redirect_cnt}, 32'hFFFF);
        jmp(8'h00, "sat_extra");
        check("sat_extra_c", {16'b0, redirect_cnt}, 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
